zrb_spi_arbiter: RTL

//  Shares one SPI byte engine (zrb_spi_rxtx-class) between N_REQ requesters. Round-robin grant held for
//  a whole transaction (CS framing), per-requester active-low chip select, CS setup/hold guard cycles,

---
 rtl/zrb_spi_pkg.sv | 16 +
 rtl/zrb_rr_arbiter.sv | 29 ++
 rtl/zrb_spi_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/zrb_spi_pkg.sv
// zrb_spi_pkg: shared state encoding and counter widths for the SPI arbiter slice
package zrb_spi_pkg;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_STALL = 3'd4,
    ST_HOLD  = 3'd5
  } state_t;
  localparam int GUARD_W = 8;
  localparam int TMO_W = 8;
  function automatic int ptr_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/zrb_rr_arbiter.sv
// zrb_rr_arbiter: combinational round-robin pick of the first request at or after ptr
module zrb_rr_arbiter
  import zrb_spi_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int PW = ptr_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PW-1:0]    idx
);
  int k;
  logic found;
  always_comb begin
    gnt = '0;
    idx = '0;
    found = 1'b0;
    k = 0;
    for (int i = 0; i < N_REQ; i++) begin
      k = (int'(ptr) + i) % N_REQ;
      if (!found && req[k]) begin
        found = 1'b1;
        gnt[k] = 1'b1;
        idx = PW'(k);
      end
    end
  end
endmodule

// File: rtl/zrb_spi_arbiter.sv
// zrb_spi_arbiter: shares one SPI byte engine among N_REQ clients with CS framing,
// guard cycles and stall-timeout abort; grant is held for the whole transaction.
module zrb_spi_arbiter
  import zrb_spi_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int NUM_BITS = 8,
  parameter int CS_GUARD = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [N_REQ-1:0]          tx_valid,
  input  logic [N_REQ-1:0]          tx_last,
  input  logic [N_REQ*NUM_BITS-1:0] tx_data,
  output logic [N_REQ-1:0]          tx_ready,
  output logic [N_REQ-1:0]          rx_valid,
  output logic [NUM_BITS-1:0]       rx_data,
  output logic [N_REQ-1:0]          abort,
  output logic [N_REQ-1:0]          cs_n,
  output logic                      eng_start,
  output logic [NUM_BITS-1:0]       eng_tx_data,
  input  logic                      eng_done,
  input  logic [NUM_BITS-1:0]       eng_rx_data
);
  localparam int PW = ptr_w(N_REQ);
  localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(CS_GUARD - 1);
  state_t state, state_d;
  logic [PW-1:0] rr, rr_d, g, g_d, arb_idx;
  logic [N_REQ-1:0] arb_gnt, g_oh, cs_n_d, rx_valid_d, abort_d;
  logic [GUARD_W-1:0] guard, guard_d;
  logic [TMO_W-1:0] stall, stall_d;
  logic [NUM_BITS-1:0] rx_data_d, eng_tx_d, g_data;
  logic last_q, last_d, eng_start_d, g_valid;
  zrb_rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_arb (
    .req(tx_valid),
    .ptr(rr),
    .gnt(arb_gnt),
    .idx(arb_idx)
  );
  assign g_oh = N_REQ'(1) << g;
  assign g_valid = tx_valid[g];
  assign g_data = tx_data[NUM_BITS*int'(g) +: NUM_BITS];
  always_comb begin
    state_d = state;
    rr_d = rr;
    g_d = g;
    guard_d = guard;
    stall_d = stall;
    last_d = last_q;
    cs_n_d = cs_n;
    rx_data_d = rx_data;
    eng_tx_d = eng_tx_data;
    rx_valid_d = '0;
    abort_d = '0;
    eng_start_d = 1'b0;
    tx_ready = '0;
    case (state)
      ST_IDLE: if (|tx_valid) begin
        g_d = arb_idx;
        cs_n_d = ~arb_gnt;
        guard_d = GUARD_LOAD;
        state_d = ST_SETUP;
      end
      ST_SETUP: if (guard == '0) state_d = ST_ISSUE; else guard_d = guard - 1'b1;
      ST_ISSUE: if (g_valid) begin
        tx_ready = g_oh;
        eng_tx_d = g_data;
        last_d = tx_last[g];
        eng_start_d = 1'b1;
        state_d = ST_WAIT;
      end else begin
        stall_d = '0;
        state_d = ST_STALL;
      end
      ST_WAIT: if (eng_done) begin
        rx_data_d = eng_rx_data;
        rx_valid_d = g_oh;
        guard_d = GUARD_LOAD;
        state_d = last_q ? ST_HOLD : ST_ISSUE;
      end
      ST_STALL: if (g_valid) state_d = ST_ISSUE;
      else if (stall == TMO_W'(TIMEOUT)) begin
        abort_d = g_oh;
        guard_d = GUARD_LOAD;
        state_d = ST_HOLD;
      end else stall_d = stall + 1'b1;
      // release leaves one IDLE cycle with every CS high before the next grant
      ST_HOLD: if (guard == '0) begin
        cs_n_d = '1;
        rr_d = (int'(g) == N_REQ - 1) ? '0 : g + 1'b1;
        state_d = ST_IDLE;
      end else guard_d = guard - 1'b1;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      rr <= '0;
      g <= '0;
      guard <= '0;
      stall <= '0;
      last_q <= 1'b0;
      cs_n <= '1;
      rx_data <= '0;
      eng_tx_data <= '0;
      rx_valid <= '0;
      abort <= '0;
      eng_start <= 1'b0;
    end else begin
      state <= state_d;
      rr <= rr_d;
      g <= g_d;
      guard <= guard_d;
      stall <= stall_d;
      last_q <= last_d;
      cs_n <= cs_n_d;
      rx_data <= rx_data_d;
      eng_tx_data <= eng_tx_d;
      rx_valid <= rx_valid_d;
      abort <= abort_d;
      eng_start <= eng_start_d;
    end
  end
endmodule
